timer_core: RTL and testbench

TIMER_CORE -- requirements
Module: timer_core

---
 rtl/timer_core.sv | 110 +++++++++++
 tb/tb_timer_core.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timer_core.sv
// Three-channel down-counting timer with a shared 1us/1ms/1s tick prescaler.
// Each channel reloads on zero and emits a one-cycle registered interrupt.

module timer_chan (
   input  logic        mclk,
   input  logic        h_reset_n,
   input  logic [2:0]  ticks,      // {1s, 1ms, 1us}
   input  logic        update,
   input  logic [18:0] cfg,        // [18:17] sel, [16] enable, [15:0] reload
   output logic        intr,
   output logic [15:0] cnt
);
   typedef enum logic {IDLE, RUN} state_t;

   state_t state;
   logic   sel_tick;

   always_comb begin
      sel_tick = 1'b0;
      case (cfg[18:17])
         2'b00:   sel_tick = ticks[0];
         2'b01:   sel_tick = ticks[1];
         2'b10:   sel_tick = ticks[2];
         default: sel_tick = 1'b0;
      endcase
   end

   // A load strobe outranks any tick landing in the same cycle.
   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         state <= IDLE;
         cnt   <= 16'd0;
         intr  <= 1'b0;
      end else begin
         intr <= 1'b0;
         if (update) begin
            cnt   <= cfg[15:0];
            state <= cfg[16] ? RUN : IDLE;
         end else if (state == RUN) begin
            if (!cfg[16]) begin
               state <= IDLE;
            end else if (sel_tick) begin
               if (cnt == 16'd0) begin
                  cnt  <= cfg[15:0];
                  intr <= 1'b1;
               end else begin
                  cnt <= cnt - 16'd1;
               end
            end
         end
      end
   end
endmodule

module timer_core #(
   parameter int NUM_TMR = 3
) (
   input  logic        mclk,
   input  logic        h_reset_n,
   input  logic [9:0]  cfg_pulse_1us,
   input  logic [2:0]  cfg_timer_update,
   input  logic [18:0] cfg_timer0,
   input  logic [18:0] cfg_timer1,
   input  logic [18:0] cfg_timer2,
   output logic [2:0]  timer_intr,
   output logic [15:0] timer_cnt0,
   output logic [15:0] timer_cnt1,
   output logic [15:0] timer_cnt2
);
   logic [9:0] pre_cnt, ms_cnt, s_cnt;
   logic       tick_1us, tick_1ms, tick_1s;

   logic [NUM_TMR-1:0][18:0] cfg_t;
   logic [NUM_TMR-1:0][15:0] cnt_t;

   // >= rather than == so a lowered prescale mid-count still fires at once.
   assign tick_1us = (pre_cnt >= cfg_pulse_1us);
   assign tick_1ms = tick_1us && (ms_cnt == 10'd999);
   assign tick_1s  = tick_1ms && (s_cnt == 10'd999);

   always_ff @(posedge mclk or negedge h_reset_n) begin
      if (!h_reset_n) begin
         pre_cnt <= 10'd0;
         ms_cnt  <= 10'd0;
         s_cnt   <= 10'd0;
      end else begin
         pre_cnt <= tick_1us ? 10'd0 : pre_cnt + 10'd1;
         if (tick_1us) ms_cnt <= tick_1ms ? 10'd0 : ms_cnt + 10'd1;
         if (tick_1ms) s_cnt  <= tick_1s  ? 10'd0 : s_cnt + 10'd1;
      end
   end

   assign cfg_t = {cfg_timer2, cfg_timer1, cfg_timer0};

   for (genvar gi = 0; gi < NUM_TMR; gi++) begin : g_chan
      timer_chan u_chan (
         .mclk      (mclk),
         .h_reset_n (h_reset_n),
         .ticks     ({tick_1s, tick_1ms, tick_1us}),
         .update    (cfg_timer_update[gi]),
         .cfg       (cfg_t[gi]),
         .intr      (timer_intr[gi]),
         .cnt       (cnt_t[gi])
      );
   end

   assign timer_cnt0 = cnt_t[0];
   assign timer_cnt1 = cnt_t[1];
   assign timer_cnt2 = cnt_t[2];
endmodule

// File: tb/tb_timer_core.sv
// Scenario bench for timer_core: expected values are queued as stimulus is
// applied and popped as the matching DUT output is sampled on the falling edge.

module tb_timer_core;
   logic        mclk, h_reset_n;
   logic [9:0]  cfg_pulse_1us;
   logic [2:0]  cfg_timer_update;
   logic [18:0] cfg_t [3];
   logic [2:0]  timer_intr;
   logic [15:0] timer_cnt0, timer_cnt1, timer_cnt2;
   logic [15:0] cnt_a [3];

   typedef struct {string nm; int v;} exp_t;
   exp_t exp_q[$];
   int   n_cmp = 0, n_err = 0;
   int   cyc = 0;

   timer_core dut (
      .mclk             (mclk),
      .h_reset_n        (h_reset_n),
      .cfg_pulse_1us    (cfg_pulse_1us),
      .cfg_timer_update (cfg_timer_update),
      .cfg_timer0       (cfg_t[0]),
      .cfg_timer1       (cfg_t[1]),
      .cfg_timer2       (cfg_t[2]),
      .timer_intr       (timer_intr),
      .timer_cnt0       (timer_cnt0),
      .timer_cnt1       (timer_cnt1),
      .timer_cnt2       (timer_cnt2)
   );

   assign cnt_a[0] = timer_cnt0;
   assign cnt_a[1] = timer_cnt1;
   assign cnt_a[2] = timer_cnt2;

   initial begin
      mclk = 1'b0;
      forever #5 mclk = ~mclk;
   end

   always @(posedge mclk) cyc <= cyc + 1;

   function automatic logic [18:0] mk(input logic [1:0] sel, input logic en, input logic [15:0] rl);
      return {sel, en, rl};
   endfunction

   // Called on a falling edge; returns on the next falling edge with the load done.
   task automatic do_update(input logic [2:0] mask);
      cfg_timer_update = mask;
      @(negedge mclk);
      cfg_timer_update = 3'b000;
   endtask

   task automatic wait_cnt(input int idx, input int val, input int max, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < max; i++) begin
         if (int'(cnt_a[idx]) == val) begin ok = 1'b1; break; end
         @(negedge mclk);
      end
   endtask

   task automatic wait_intr(input int idx, input int max, output bit ok, output int at);
      ok = 1'b0;
      at = -100000;
      for (int i = 0; i < max; i++) begin
         if (timer_intr[idx]) begin ok = 1'b1; at = cyc; break; end
         @(negedge mclk);
      end
   endtask

   task automatic test_reset;
      exp_t e;
      int   obs;
      h_reset_n        = 1'b0;
      cfg_pulse_1us    = 10'd9;
      cfg_timer_update = 3'b000;
      for (int i = 0; i < 3; i++) cfg_t[i] = mk(2'b00, 1'b1, 16'd5);
      repeat (3) @(negedge mclk);
      exp_q.push_back('{"rst_intr", 0});
      exp_q.push_back('{"rst_cnt0", 0});
      exp_q.push_back('{"rst_cnt1", 0});
      exp_q.push_back('{"rst_cnt2", 0});
      for (int i = 0; i < 4; i++) begin
         obs = (i == 0) ? int'(timer_intr) : int'(cnt_a[i-1]);
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e.v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", e.nm, obs, e.v);
         end
      end
      h_reset_n = 1'b1;
      @(negedge mclk);
   endtask

   task automatic test_prescaler;
      exp_t e;
      bit   ok;
      int   t0, t1;
      cfg_pulse_1us = 10'd9;
      cfg_t[0] = mk(2'b00, 1'b1, 16'd0);
      do_update(3'b001);
      wait_intr(0, 30, ok, t0);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL pre_first: no interrupt in 30 cycles"); end
      exp_q.push_back('{"pre9_ivl", 10});
      exp_q.push_back('{"pre9_ivl", 10});
      for (int k = 0; k < 2; k++) begin
         @(negedge mclk);
         wait_intr(0, 30, ok, t1);
         e = exp_q.pop_front();
         n_cmp++;
         if (t1 - t0 !== e.v) begin
            n_err++;
            $display("FAIL %s: got %0d cycles, want %0d", e.nm, t1 - t0, e.v);
         end
         t0 = t1;
      end
      // Prescaler count is 0 in the interrupt cycle, so it reads 7 seven cycles on.
      repeat (7) @(negedge mclk);
      cfg_pulse_1us = 10'd3;
      exp_q.push_back('{"pre3_first", 8});
      exp_q.push_back('{"pre3_ivl", 4});
      exp_q.push_back('{"pre3_ivl", 4});
      for (int k = 0; k < 3; k++) begin
         if (k > 0) @(negedge mclk);
         wait_intr(0, 30, ok, t1);
         e = exp_q.pop_front();
         n_cmp++;
         if (t1 - t0 !== e.v) begin
            n_err++;
            $display("FAIL %s: got %0d cycles, want %0d", e.nm, t1 - t0, e.v);
         end
         t0 = t1;
      end
      @(negedge mclk);
   endtask

   task automatic test_periodic;
      exp_t e;
      int   c_seq [7] = '{4, 3, 2, 1, 0, 4, 3};
      int   i_seq [7] = '{0, 0, 0, 0, 0, 1, 0};
      cfg_pulse_1us = 10'd0;
      cfg_t[0] = mk(2'b00, 1'b1, 16'd4);
      for (int k = 0; k < 7; k++) begin
         exp_q.push_back('{"per_cnt0", c_seq[k]});
         exp_q.push_back('{"per_intr0", i_seq[k]});
      end
      do_update(3'b001);
      for (int k = 0; k < 7; k++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(timer_cnt0) !== e.v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", e.nm, k, timer_cnt0, e.v);
         end
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(timer_intr[0]) !== e.v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", e.nm, k, timer_intr[0], e.v);
         end
         @(negedge mclk);
      end
   endtask

   task automatic test_collision;
      exp_t e;
      bit   ok;
      int   c_seq [4] = '{2, 1, 0, 2};
      int   i_seq [4] = '{0, 0, 0, 1};
      cfg_t[1] = mk(2'b00, 1'b1, 16'd3);
      do_update(3'b010);
      wait_cnt(1, 0, 10, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL col_reach0: cnt1 never reached 0"); end
      cfg_t[1] = mk(2'b00, 1'b1, 16'd2);
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back('{"col_cnt1", c_seq[k]});
         exp_q.push_back('{"col_intr1", i_seq[k]});
      end
      do_update(3'b010);
      for (int k = 0; k < 4; k++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(timer_cnt1) !== e.v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", e.nm, k, timer_cnt1, e.v);
         end
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(timer_intr[1]) !== e.v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", e.nm, k, timer_intr[1], e.v);
         end
         @(negedge mclk);
      end
   endtask

   task automatic test_disable_select;
      exp_t e;
      bit   ok;
      int   n_int;
      cfg_t[0] = mk(2'b00, 1'b1, 16'd20);
      do_update(3'b001);
      wait_cnt(0, 7, 30, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL dis_reach7: cnt0 never reached 7"); end
      cfg_t[0] = mk(2'b00, 1'b0, 16'd20);
      exp_q.push_back('{"dis_cnt0", 7});
      exp_q.push_back('{"dis_intr0", 0});
      n_int = 0;
      repeat (10) begin
         @(negedge mclk);
         if (timer_intr[0]) n_int++;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(timer_cnt0) !== e.v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", e.nm, timer_cnt0, e.v);
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (n_int !== e.v) begin
         n_err++;
         $display("FAIL %s: got %0d pulses, want %0d", e.nm, n_int, e.v);
      end
      // Re-enabling without a load must leave the channel idle.
      cfg_t[0] = mk(2'b00, 1'b1, 16'd20);
      exp_q.push_back('{"reen_cnt0", 7});
      repeat (5) @(negedge mclk);
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(timer_cnt0) !== e.v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", e.nm, timer_cnt0, e.v);
      end
      cfg_t[0] = mk(2'b11, 1'b1, 16'd9);
      exp_q.push_back('{"sel11_cnt0", 9});
      do_update(3'b001);
      repeat (5) @(negedge mclk);
      e = exp_q.pop_front();
      n_cmp++;
      if (int'(timer_cnt0) !== e.v) begin
         n_err++;
         $display("FAIL %s: got %0d, want %0d", e.nm, timer_cnt0, e.v);
      end
      cfg_t[0] = mk(2'b00, 1'b1, 16'd9);
      exp_q.push_back('{"sel00_cnt0", 8});
      exp_q.push_back('{"sel00_cnt0", 7});
      for (int k = 0; k < 2; k++) begin
         @(negedge mclk);
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(timer_cnt0) !== e.v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", e.nm, k, timer_cnt0, e.v);
         end
      end
   endtask

   task automatic test_1ms;
      exp_t e;
      bit   ok;
      int   t0, t1;
      int   i_seq [5] = '{0, 7, 7, 7, 7};
      cfg_pulse_1us = 10'd0;
      cfg_t[2] = mk(2'b01, 1'b1, 16'd1);
      do_update(3'b100);
      wait_intr(2, 2500, ok, t0);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL ms_first: no timer2 interrupt in 2500 cycles"); end
      exp_q.push_back('{"ms_ivl", 2000});
      exp_q.push_back('{"ms_ivl", 2000});
      for (int k = 0; k < 2; k++) begin
         @(negedge mclk);
         wait_intr(2, 2100, ok, t1);
         e = exp_q.pop_front();
         n_cmp++;
         if (t1 - t0 !== e.v) begin
            n_err++;
            $display("FAIL %s: got %0d cycles, want %0d", e.nm, t1 - t0, e.v);
         end
         t0 = t1;
      end
      @(negedge mclk);
      for (int i = 0; i < 3; i++) cfg_t[i] = mk(2'b00, 1'b1, 16'd0);
      for (int k = 0; k < 5; k++) exp_q.push_back('{"all_intr", i_seq[k]});
      do_update(3'b111);
      for (int k = 0; k < 5; k++) begin
         e = exp_q.pop_front();
         n_cmp++;
         if (int'(timer_intr) !== e.v) begin
            n_err++;
            $display("FAIL %s[%0d]: got %0d, want %0d", e.nm, k, timer_intr, e.v);
         end
         @(negedge mclk);
      end
   endtask

   task automatic test_reset_midrun;
      exp_t e;
      bit   ok;
      int   obs, n_int, t0, t1;
      cfg_pulse_1us = 10'd0;
      cfg_t[0] = mk(2'b00, 1'b1, 16'd10);
      do_update(3'b001);
      wait_cnt(0, 3, 20, ok);
      n_cmp++;
      if (!ok) begin n_err++; $display("FAIL mid_reach3: cnt0 never reached 3"); end
      h_reset_n = 1'b0;
      #1;
      exp_q.push_back('{"mid_intr", 0});
      exp_q.push_back('{"mid_cnt0", 0});
      exp_q.push_back('{"mid_cnt1", 0});
      exp_q.push_back('{"mid_cnt2", 0});
      for (int i = 0; i < 4; i++) begin
         obs = (i == 0) ? int'(timer_intr) : int'(cnt_a[i-1]);
         e = exp_q.pop_front();
         n_cmp++;
         if (obs !== e.v) begin
            n_err++;
            $display("FAIL %s: got %0d, want %0d", e.nm, obs, e.v);
         end
      end
      @(negedge mclk);
      h_reset_n = 1'b1;
      exp_q.push_back('{"post_rst_intrs", 0});
      n_int = 0;
      repeat (150) begin
         @(negedge mclk);
         if (timer_intr != 3'b000) n_int++;
      end
      e = exp_q.pop_front();
      n_cmp++;
      if (n_int !== e.v) begin
         n_err++;
         $display("FAIL %s: got %0d pulses, want %0d", e.nm, n_int, e.v);
      end
      // First 1us tick after release lands cfg_pulse_1us+1 cycles later.
      h_reset_n     = 1'b0;
      cfg_pulse_1us = 10'd4;
      cfg_t[0]      = mk(2'b00, 1'b1, 16'd0);
      @(negedge mclk);
      h_reset_n = 1'b1;
      t0 = cyc;
      exp_q.push_back('{"rel_first_tick", 5});
      do_update(3'b001);
      wait_intr(0, 20, ok, t1);
      e = exp_q.pop_front();
      n_cmp++;
      if (t1 - t0 !== e.v) begin
         n_err++;
         $display("FAIL %s: got %0d cycles, want %0d", e.nm, t1 - t0, e.v);
      end
   endtask

   initial begin
      test_reset;
      test_prescaler;
      test_periodic;
      test_collision;
      test_disable_select;
      test_1ms;
      test_reset_midrun;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end
endmodule
